// File: rtl/reg_dump.sv
// reg_dump: debug reader for the CPU register file. Halts the CPU, walks a
// register range through one read port and streams each word out over a
// valid/ready interface, then releases the halt.
module reg_dump #(
  parameter int DATA_W      = 32,
  parameter int AW          = 5,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AW-1:0]     first_reg,
  input  logic [AW-1:0]     last_reg,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AW-1:0]     out_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] last_q;
  logic [TW-1:0] timer;
  logic          timeout_hit;
  logic          last_word;

  // The final waiting cycle is the one where the count has reached ACK_TIMEOUT-1.
  assign timeout_hit = (timer == TW'(ACK_TIMEOUT - 1));
  assign last_word   = (out_idx == last_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; control outputs follow directly from the current state
  // so they are clean registered-state decodes and drop at once on reset.
  always_comb begin
    state_nxt = state;
    halt_req  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HALT;
      end
      S_HALT: begin
        halt_req = 1'b1;
        busy     = 1'b1;
        if (halt_ack)         state_nxt = S_READ;
        else if (timeout_hit) state_nxt = S_DONE;
      end
      S_READ: begin
        halt_req = 1'b1;
        busy     = 1'b1;
        if (halt_ack) state_nxt = S_SEND;
      end
      S_SEND: begin
        halt_req  = 1'b1;
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = last_word ? S_DONE : S_READ;
      end
      S_DONE: begin
        halt_req  = 1'b1;
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address walk, halt timeout counter, error flag and output word capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr  <= '0;
      last_q   <= '0;
      timer    <= '0;
      err      <= 1'b0;
      out_data <= '0;
      out_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_addr <= first_reg;
            last_q  <= last_reg;
            timer   <= '0;
            err     <= 1'b0;
          end
        end
        S_HALT: begin
          if (!halt_ack) begin
            timer <= timer + TW'(1);
            if (timeout_hit) err <= 1'b1;
          end
        end
        S_READ: begin
          // Read data is only trusted while the CPU confirms the port is ours.
          if (halt_ack) begin
            out_data <= rd_data;
            out_idx  <= rd_addr;
          end
        end
        S_SEND: begin
          // Index wraps modulo 2**AW, so first_reg > last_reg walks the wrapped range.
          if (out_ready && !last_word) rd_addr <= rd_addr + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed bench for reg_dump with a queue-based reference model
// checked every cycle plus literal expectations per scenario.
module tb_reg_dump;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 12;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] first_reg;
  logic [AW-1:0] last_reg;
  logic          halt_req;
  logic          halt_ack;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          busy;
  logic          done;
  logic          err;

  reg_dump #(.DATA_W(DW), .AW(AW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_reg(first_reg),
    .last_reg(last_reg), .halt_req(halt_req), .halt_ack(halt_ack),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: r0 reads 0, ri = 0x1000+i. Garbage when the port is not granted.
  logic [DW-1:0] regs [32];
  assign rd_data = halt_ack ? regs[rd_addr] : 32'hDEAD_BEEF;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] reg_val(input logic [AW-1:0] i);
    return (i == 0) ? '0 : (32'h1000 + DW'(i));
  endfunction

  // ---------------- reference model ----------------
  logic [AW-1:0] mq[$];      // indices still to be delivered
  logic [AW-1:0] rx_idx[$];  // delivered indices (handshakes)
  logic [DW-1:0] rx_data[$];
  logic          mbusy = 1'b0;
  logic          m_err = 1'b0;
  logic          exp_err = 1'b0;
  int            sent = 0;
  logic [AW-1:0] mi;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mbusy = 1'b0;
      m_err = 1'b0;
      sent  = 0;
      chk("reset_ctrl", {out_valid, halt_req, busy, done, err}, 5'b0);
      chk("reset_data", {out_data, out_idx, rd_addr}, '0);
    end else begin
      chk("busy", busy, mbusy);
      chk("halt_req", halt_req, mbusy);
      if (out_valid) begin
        if (mq.size() == 0) begin
          chk("unexpected_word", out_valid, 1'b0);
        end else begin
          chk("out_idx", out_idx, mq[0]);
          chk("out_data", out_data, reg_val(mq[0]));
        end
      end
      if (done) begin
        chk("done_while_idle", mbusy, 1'b1);
        chk("err_at_done", err, exp_err);
        if (!exp_err) chk("words_left_at_done", mq.size(), 0);
        else          chk("words_sent_on_abort", sent, 0);
      end else begin
        chk("err_hold", err, m_err);
      end
      // advance the model to the upcoming clock edge
      if (out_valid && out_ready && mq.size() > 0) begin
        rx_idx.push_back(out_idx);
        rx_data.push_back(out_data);
        void'(mq.pop_front());
        sent++;
      end
      if (done) begin
        mbusy = 1'b0;
        m_err = exp_err;
        mq.delete();
      end else if (!mbusy && start) begin
        mbusy = 1'b1;
        m_err = 1'b0;
        sent  = 0;
        mq.delete();
        mi = first_reg;
        mq.push_back(mi);
        while (mi != last_reg) begin
          mi = mi + AW'(1);
          mq.push_back(mi);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic rx_clear();
    rx_idx.delete();
    rx_data.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int n;
  int m;
  logic [AW-1:0] exp2 [4];

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? '0 : (32'h1000 + i);
    rst_n = 1'b1; start = 1'b0; first_reg = '0; last_reg = '0;
    halt_ack = 1'b1; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", busy, 1'b0);
    chk("init_halt_req", halt_req, 1'b0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: full sweep 0..31
    rx_clear();
    first_reg = 0; last_reg = 31; start = 1'b1; n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk("t1_first_valid_latency", n, 3);
    wait_done(200, m);
    chk("t1_total_cycles", n + m, 66);
    chk("t1_count", rx_idx.size(), 32);
    chk("t1_idx0", rx_idx[0], 0);
    chk("t1_data0", rx_data[0], 0);
    chk("t1_data1", rx_data[1], 32'h1001);
    chk("t1_idx31", rx_idx[31], 31);
    chk("t1_data31", rx_data[31], 32'h101F);

    // 2: wrapped range 30..1
    rx_clear();
    exp2[0] = 30; exp2[1] = 31; exp2[2] = 0; exp2[3] = 1;
    pulse_start(30, 1);
    wait_done(50, m);
    chk("t2_cycles", m, 9);
    chk("t2_count", rx_idx.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_idx_seq", rx_idx[i], exp2[i]);

    // 3: halt_ack never arrives -> abort
    rx_clear();
    halt_ack = 1'b0; exp_err = 1'b1;
    pulse_start(2, 6);
    wait_done(TO + 20, m);
    chk("t3_abort_cycles", m, TO);
    chk("t3_halt_req_after", halt_req, 1'b0);
    chk("t3_err_held", err, 1'b1);
    chk("t3_words", rx_idx.size(), 0);
    halt_ack = 1'b1; exp_err = 1'b0;

    // 4: single word with random back-pressure; starts while busy / in DONE ignored
    rx_clear();
    first_reg = 5; last_reg = 5; start = 1'b1; out_ready = 1'b0; n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      if (n == 3) begin
        first_reg = 10; last_reg = 12; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      out_ready = (n < 6) ? 1'b0 : 1'(($urandom_range(0, 1)));
      n++;
    end
    chk("t4_done_seen", done, 1'b1);
    first_reg = 20; last_reg = 20; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t4_start_in_done_ignored", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_still_idle", busy, 1'b0);
    chk("t4_count", rx_idx.size(), 1);
    chk("t4_idx", rx_idx[0], 5);
    chk("t4_data", rx_data[0], 32'h1005);

    // 5: halt_ack drops while in READ
    rx_clear();
    pulse_start(7, 9);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    halt_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("t5_no_capture", out_valid, 1'b0);
    end
    halt_ack = 1'b1;
    wait_done(50, m);
    chk("t5_count", rx_idx.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t5_idx", rx_idx[i], 7 + i);
      chk("t5_data", rx_data[i], 32'h1007 + i);
    end

    // 6: asynchronous reset while stalled in SEND
    rx_clear();
    out_ready = 1'b0;
    pulse_start(4, 31);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_in_send", {out_valid, out_idx}, {1'b1, 5'd4});
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_ctrl", {out_valid, halt_req, busy, done, err}, 5'b0);
    chk("t6_async_data", out_data, 0);
    chk("t6_async_idx", out_idx, 0);
    chk("t6_async_addr", rd_addr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk("t6_no_done", done, 1'b0);
      @(posedge clk); #1;
    end
    rx_clear();
    pulse_start(3, 4);
    wait_done(50, m);
    chk("t6_recover_count", rx_idx.size(), 2);
    chk("t6_recover_idx", rx_idx[1], 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
